// File: rtl/id_hazard_scoreboard.sv
// ID-stage hazard/forwarding scoreboard: per-stage record of in-flight rd writes (EX..WB).
// Build option ID_HAZ_FWD_EN enables operand forwarding; without it, any non-WB match stalls.
module id_hazard_scoreboard #(
   parameter int NUM_STAGES = 3,
   parameter int REG_W      = 5,
   parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs1,
   input  logic             id_rs1_used,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_rs2_used,
   input  logic             id_rs2_late,
   input  logic [REG_W-1:0] id_rd,
   input  logic             id_rd_we,
   input  logic [SEL_W-1:0] id_rdy_stage,
   input  logic             hold,
   input  logic             flush,
   output logic             stall,
   output logic             issue,
   output logic [SEL_W-1:0] fwd_sel_rs1,
   output logic [SEL_W-1:0] fwd_sel_rs2,
   output logic [SEL_W-1:0] inflight_cnt
);

   // Index k: 1 = EX ... NUM_STAGES = WB. v is only set for real (we=1, rd!=0) writes.
   logic [NUM_STAGES:1] v_q, v_d;
   logic [REG_W-1:0]    rd_q [1:NUM_STAGES];
   logic [REG_W-1:0]    rd_d [1:NUM_STAGES];

   logic             hit1, hit2;
   logic [SEL_W-1:0] k1, k2;
   logic             haz1, haz2;

`ifdef ID_HAZ_FWD_EN
   logic [SEL_W-1:0] rdy_q [1:NUM_STAGES];
   logic [SEL_W-1:0] rdy_d [1:NUM_STAGES];
   logic [SEL_W-1:0] rdy1, rdy2, rdy_in;
   logic [SEL_W:0]   need2;
`endif

   // Scan oldest to youngest so the youngest matching entry is the one left standing.
   always_comb begin
      hit1 = 1'b0;
      hit2 = 1'b0;
      k1   = '0;
      k2   = '0;
`ifdef ID_HAZ_FWD_EN
      rdy1 = '0;
      rdy2 = '0;
`endif
      for (int k = NUM_STAGES; k >= 1; k--) begin
         if (id_rs1_used && id_rs1 != '0 && v_q[k] && rd_q[k] == id_rs1) begin
            hit1 = 1'b1;
            k1   = SEL_W'(k);
`ifdef ID_HAZ_FWD_EN
            rdy1 = rdy_q[k];
`endif
         end
         if (id_rs2_used && id_rs2 != '0 && v_q[k] && rd_q[k] == id_rs2) begin
            hit2 = 1'b1;
            k2   = SEL_W'(k);
`ifdef ID_HAZ_FWD_EN
            rdy2 = rdy_q[k];
`endif
         end
      end
   end

`ifdef ID_HAZ_FWD_EN
   // Store data is consumed one stage later, so it tolerates one more stage of latency.
   assign need2       = {1'b0, k2} + {{SEL_W{1'b0}}, id_rs2_late};
   assign haz1        = hit1 && (rdy1 > k1);
   assign haz2        = hit2 && ({1'b0, rdy2} > need2);
   assign fwd_sel_rs1 = k1;
   assign fwd_sel_rs2 = k2;
   assign rdy_in      = (id_rdy_stage == '0 || id_rdy_stage > SEL_W'(NUM_STAGES))
                        ? SEL_W'(NUM_STAGES) : id_rdy_stage;
`else
   // Regfile is written in the first half of WB here, so only pre-WB matches stall.
   logic unused_cfg;
   assign unused_cfg  = ^{id_rdy_stage, id_rs2_late};
   assign haz1        = hit1 && (k1 < SEL_W'(NUM_STAGES));
   assign haz2        = hit2 && (k2 < SEL_W'(NUM_STAGES));
   assign fwd_sel_rs1 = '0;
   assign fwd_sel_rs2 = '0;
`endif

   // stall: ID holds its instruction. issue: the ID instruction is accepted into EX this
   // cycle; it is the only event that inserts a live entry, everything else inserts a bubble.
   assign stall = id_valid && (haz1 || haz2);
   assign issue = id_valid && !stall && !hold && !flush;

   always_comb begin
      v_d  = v_q;
      rd_d = rd_q;
`ifdef ID_HAZ_FWD_EN
      rdy_d = rdy_q;
`endif
      if (!hold) begin
         for (int k = 2; k <= NUM_STAGES; k++) begin
            v_d[k]  = v_q[k-1] && !(k == 2 && flush);
            rd_d[k] = rd_q[k-1];
`ifdef ID_HAZ_FWD_EN
            rdy_d[k] = rdy_q[k-1];
`endif
         end
         v_d[1]  = issue && id_rd_we && (id_rd != '0);
         rd_d[1] = id_rd;
`ifdef ID_HAZ_FWD_EN
         rdy_d[1] = rdy_in;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q <= '0;
         for (int k = 1; k <= NUM_STAGES; k++) begin
            rd_q[k] <= '0;
`ifdef ID_HAZ_FWD_EN
            rdy_q[k] <= '0;
`endif
         end
      end else begin
         v_q  <= v_d;
         rd_q <= rd_d;
`ifdef ID_HAZ_FWD_EN
         rdy_q <= rdy_d;
`endif
      end
   end

   always_comb begin
      inflight_cnt = '0;
      for (int k = 1; k <= NUM_STAGES; k++) begin
         inflight_cnt = inflight_cnt + SEL_W'(v_q[k]);
      end
   end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Directed bench for id_hazard_scoreboard (NUM_STAGES=3); expectations follow the
// ID_HAZ_FWD_EN build selection. Driver pushes expected outputs, monitor compares at negedge.
module tb_id_hazard_scoreboard;

   localparam int N     = 3;
   localparam int SEL_W = 2;
   localparam int W     = 2 + 3 * SEL_W;
   localparam int STL   = 7;  // expected-result code meaning "stalled"

`ifdef ID_HAZ_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic             clk, rst_n;
   logic             id_valid, id_rs1_used, id_rs2_used, id_rs2_late, id_rd_we, hold, flush;
   logic [4:0]       id_rs1, id_rs2, id_rd;
   logic [SEL_W-1:0] id_rdy_stage;
   logic             stall, issue;
   logic [SEL_W-1:0] fwd_sel_rs1, fwd_sel_rs2, inflight_cnt;

   logic [W-1:0] exp_q[$];
   int n_vec  = 0;
   int n_miss = 0;

   id_hazard_scoreboard #(.NUM_STAGES(N), .REG_W(5), .SEL_W(SEL_W)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
      .id_rs2(id_rs2), .id_rs2_used(id_rs2_used), .id_rs2_late(id_rs2_late),
      .id_rd(id_rd), .id_rd_we(id_rd_we), .id_rdy_stage(id_rdy_stage),
      .hold(hold), .flush(flush),
      .stall(stall), .issue(issue),
      .fwd_sel_rs1(fwd_sel_rs1), .fwd_sel_rs2(fwd_sel_rs2), .inflight_cnt(inflight_cnt)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // driver tasks
   task automatic step(input logic v, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2, input logic lt,
                       input logic [4:0] d, input logic we, input logic [1:0] rs,
                       input logic h, input logic f,
                       input logic es, input logic ei, input logic [1:0] ef1,
                       input logic [1:0] ef2, input logic [1:0] ec);
      @(posedge clk);
      #1;
      id_valid = v; id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
      id_rs2_late = lt; id_rd = d; id_rd_we = we; id_rdy_stage = rs; hold = h; flush = f;
      exp_q.push_back({es, ei, ef1, ef2, ec});
   endtask

   task automatic idle(input logic [1:0] c);
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, c);
   endtask

   task automatic wr(input logic [4:0] d, input logic [1:0] rs, input logic [1:0] c);
      step(1, 0, 0, 0, 0, 0, d, 1, rs, 0, 0, 0, 1, 0, 0, c);
   endtask

   // fw / nf: expected forward select (or STL) for the forwarding / non-forwarding build
   task automatic rd1(input logic [4:0] r, input logic h, input int fw, input int nf,
                      input logic [1:0] c);
      int   e;
      logic s;
      e = FWD ? fw : nf;
      s = (e == STL);
      step(1, r, 1, 0, 0, 0, 0, 0, 1, h, 0, s, !s && !h, s ? 2'd0 : 2'(e), 0, c);
   endtask

   task automatic rd2(input logic [4:0] r, input logic lt, input int fw, input int nf,
                      input logic [1:0] c);
      int   e;
      logic s;
      e = FWD ? fw : nf;
      s = (e == STL);
      step(1, 0, 0, r, 1, lt, 0, 0, 1, 0, 0, s, !s, 0, s ? 2'd0 : 2'(e), c);
   endtask

   // scoreboard monitor: forward selects are don't-care while a stall is expected
   initial begin
      logic [W-1:0] e, a, m;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {stall, issue, fwd_sel_rs1, fwd_sel_rs2, inflight_cnt};
            m = e[W-1] ? {2'b11, {(2*SEL_W){1'b0}}, {SEL_W{1'b1}}} : {W{1'b1}};
            if ((a & m) !== (e & m)) begin
               n_miss++;
               $display("FAIL vec%0d: got stall=%0b issue=%0b f1=%0d f2=%0d cnt=%0d, want stall=%0b issue=%0b f1=%0d f2=%0d cnt=%0d",
                        n_vec, a[7], a[6], a[5:4], a[3:2], a[1:0],
                        e[7], e[6], e[5:4], e[3:2], e[1:0]);
            end
            n_vec++;
         end
      end
   end

   // directed stimulus
   initial begin
      rst_n = 1'b0;
      id_valid = 0; id_rs1 = 0; id_rs1_used = 0; id_rs2 = 0; id_rs2_used = 0;
      id_rs2_late = 0; id_rd = 0; id_rd_we = 0; id_rdy_stage = 1; hold = 0; flush = 0;

      idle(0);                      // sampled while still in reset
      @(negedge clk); #1 rst_n = 1'b1;
      idle(0);

      // ALU producer x5, readers in EX, MEM, WB positions
      wr(5, 1, 0);
      rd1(5, 0, 1, STL, 1);
      rd1(5, 0, 2, STL, 1);
      rd1(5, 0, 3, 0, 1);
      idle(0);

      // load x7 consumed as rs2
      wr(7, 2, 0);
      rd2(7, 0, STL, STL, 1);
      rd2(7, 0, 2, STL, 1);
      rd2(7, 0, 3, 0, 1);

      // load x7 consumed as store data
      wr(7, 2, 0);
      rd2(7, 1, 1, STL, 1);
      rd2(7, 1, 2, STL, 1);
      rd2(7, 1, 3, 0, 1);

      // two writers of x3: youngest wins
      wr(3, 1, 0);
      wr(3, 1, 1);
      rd1(3, 0, 1, STL, 2);
      rd1(3, 0, 2, STL, 2);
      rd1(3, 0, 3, 0, 1);

      // x0 write never tracked, x0 reads never hazard
      wr(0, 1, 0);
      step(1, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);

      // load x9 with 4 held cycles
      wr(9, 2, 0);
      repeat (4) rd1(9, 1, STL, STL, 1);
      rd1(9, 0, STL, STL, 1);
      rd1(9, 0, 2, STL, 1);
      rd1(9, 0, 3, 0, 1);

      // flush squashes the x4 entry
      wr(4, 1, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1);
      rd1(4, 0, 0, 0, 0);

      // hold overrides flush: x4 entry survives
      wr(4, 1, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1);
      rd1(4, 0, 1, STL, 1);
      idle(1);
      idle(1);
      idle(0);

      // out-of-range ready stage clamps to WB
      wr(6, 0, 0);
      rd1(6, 0, STL, STL, 1);
      rd1(6, 0, STL, STL, 1);
      rd1(6, 0, 3, 0, 1);

      // asynchronous reset in the middle of a stall
      wr(9, 2, 0);
      rd1(9, 0, STL, STL, 1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      if (stall !== 1'b0 || issue !== 1'b1 || inflight_cnt !== 2'd0) begin
         n_miss++;
         $display("FAIL async_reset: got stall=%0b issue=%0b cnt=%0d, want stall=0 issue=1 cnt=0",
                  stall, issue, inflight_cnt);
      end
      n_vec++;
      #1 rst_n = 1'b1;
      rd1(9, 0, 0, 0, 0);
      idle(0);

      // drain the expected queue within a bounded number of cycles
      for (int i = 0; i < 10; i++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk);
      end
      if (exp_q.size() != 0) begin
         n_miss++;
         $display("FAIL drain: got %0d pending vectors, want 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
